// File: rtl/servo_pid_multi.sv
// N-channel servo loop: one time-multiplexed PID datapath (single multiplier)
// feeding N glitch-free PWM generators with shadowed duty registers.
module servo_pid_multi #(
  parameter int WIDTH = 12,
  parameter int N_CH  = 2,
  parameter int FRAC  = 8,
  parameter int ACCW  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    dataf_i,
  input  logic [N_CH*WIDTH-1:0]   adc_i,
  input  logic [N_CH*WIDTH-1:0]   ref_i,
  input  logic [WIDTH-1:0]        kp_i,
  input  logic [WIDTH-1:0]        ki_i,
  input  logic [WIDTH-1:0]        kd_i,
  output logic [N_CH-1:0]         pwm_o,
  output logic [N_CH-1:0]         sat_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int EW = WIDTH + 1;          // error
  localparam int DW = WIDTH + 2;          // error delta
  localparam int PW = EW + ACCW;          // multiplier product
  localparam int AW = WIDTH + ACCW + 3;   // accumulator
  localparam logic signed [ACCW:0]   SUM_MAX = (ACCW+1)'((2 ** (ACCW-1)) - 1);
  localparam logic signed [ACCW:0]   SUM_MIN = -SUM_MAX;
  localparam logic [WIDTH-1:0]       DUTY_MAX = '1;
  localparam logic [CW-1:0]          LAST_CH  = CW'(N_CH - 1);

  typedef enum logic [2:0] {IDLE, S_ERR, S_P, S_I, S_D, S_WR, S_DONE} state_t;

  state_t state, next_state;
  logic [CW-1:0] ch;

  logic [WIDTH-1:0] adc_s [N_CH];
  logic [WIDTH-1:0] ref_s [N_CH];
  logic [WIDTH-1:0] kp_s, ki_s, kd_s;

  logic signed [ACCW-1:0] integ  [N_CH];
  logic signed [EW-1:0]   e_prev [N_CH];
  logic [N_CH-1:0]        sat_hi, sat_lo;
  logic [WIDTH-1:0]       duty_shadow [N_CH];
  logic [WIDTH-1:0]       duty_active [N_CH];

  logic signed [EW-1:0]   e_r;
  logic signed [DW-1:0]   d_r;
  logic signed [ACCW-1:0] i_new_r;
  logic signed [AW-1:0]   acc;

  logic frame_start, last_ch, in_compute;
  logic busy_d, done_d, ovr_d;

  assign frame_start = dataf_i && enable_i && (state == IDLE || state == S_DONE);
  assign last_ch     = (ch == LAST_CH);
  assign in_compute  = (state inside {S_ERR, S_P, S_I, S_D, S_WR});

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    if (!enable_i) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE, S_DONE: next_state = frame_start ? S_ERR : IDLE;
        S_ERR:        next_state = S_P;
        S_P:          next_state = S_I;
        S_I:          next_state = S_D;
        S_D:          next_state = S_WR;
        S_WR:         next_state = last_ch ? S_DONE : S_ERR;
        default:      next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = next_state inside {S_ERR, S_P, S_I, S_D, S_WR};
    done_d = enable_i && (state == S_DONE);
    ovr_d  = enable_i && dataf_i && in_compute;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      busy_o    <= busy_d;
      done_o    <= done_d;
      overrun_o <= ovr_d;
    end
  end

  // Error, delta and saturated/anti-windup integral for the current channel
  logic signed [EW-1:0]   e_c;
  logic signed [DW-1:0]   d_c;
  logic signed [ACCW:0]   i_sum;
  logic signed [ACCW-1:0] i_next;
  logic                   hold;

  always_comb begin
    e_c   = $signed({1'b0, ref_s[ch]}) - $signed({1'b0, adc_s[ch]});
    d_c   = {e_c[EW-1], e_c} - {e_prev[ch][EW-1], e_prev[ch]};
    i_sum = {integ[ch][ACCW-1], integ[ch]} + {{(ACCW+1-EW){e_c[EW-1]}}, e_c};
    hold  = (sat_hi[ch] && !e_c[EW-1] && (e_c != '0)) || (sat_lo[ch] && e_c[EW-1]);
    if (hold)                 i_next = integ[ch];
    else if (i_sum > SUM_MAX) i_next = ACCW'(SUM_MAX);
    else if (i_sum < SUM_MIN) i_next = ACCW'(SUM_MIN);
    else                      i_next = ACCW'(i_sum);
  end

  // Shared multiplier: gain operand and signal operand selected by phase
  logic signed [EW-1:0]   mul_a;
  logic signed [ACCW-1:0] mul_b;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   prod_x, u_c;
  logic                   u_lo, u_hi;

  always_comb begin
    unique case (state)
      S_P:     begin mul_a = {1'b0, kp_s}; mul_b = {{(ACCW-EW){e_r[EW-1]}}, e_r}; end
      S_I:     begin mul_a = {1'b0, ki_s}; mul_b = i_new_r; end
      default: begin mul_a = {1'b0, kd_s}; mul_b = {{(ACCW-DW){d_r[DW-1]}}, d_r}; end
    endcase
    prod   = mul_a * mul_b;
    prod_x = {{(AW-PW){prod[PW-1]}}, prod};
    u_c    = acc >>> FRAC;
    u_lo   = u_c[AW-1];
    u_hi   = !u_c[AW-1] && (|u_c[AW-2:WIDTH]);
  end

  // NOTE: the per-channel arrays are true registers that must come up cleared,
  // so they are reset element by element rather than left as uninitialised RAM.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      ch      <= '0;
      kp_s    <= '0;
      ki_s    <= '0;
      kd_s    <= '0;
      e_r     <= '0;
      d_r     <= '0;
      i_new_r <= '0;
      acc     <= '0;
      sat_hi  <= '0;
      sat_lo  <= '0;
      sat_o   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        adc_s[k]       <= '0;
        ref_s[k]       <= '0;
        integ[k]       <= '0;
        e_prev[k]      <= '0;
        duty_shadow[k] <= '0;
      end
    end else if (!enable_i) begin
      ch     <= '0;
      sat_hi <= '0;
      sat_lo <= '0;
      sat_o  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        integ[k]       <= '0;
        e_prev[k]      <= '0;
        duty_shadow[k] <= '0;
      end
    end else begin
      if (frame_start) begin
        ch   <= '0;
        kp_s <= kp_i;
        ki_s <= ki_i;
        kd_s <= kd_i;
        for (int k = 0; k < N_CH; k++) begin
          adc_s[k] <= adc_i[k*WIDTH +: WIDTH];
          ref_s[k] <= ref_i[k*WIDTH +: WIDTH];
        end
      end
      unique case (state)
        S_ERR: begin
          e_r     <= e_c;
          d_r     <= d_c;
          i_new_r <= i_next;
        end
        S_P:      acc <= prod_x;
        S_I, S_D: acc <= acc + prod_x;
        S_WR: begin
          duty_shadow[ch] <= u_lo ? '0 : (u_hi ? DUTY_MAX : u_c[WIDTH-1:0]);
          sat_o[ch]       <= u_lo || u_hi;
          sat_hi[ch]      <= u_hi;
          sat_lo[ch]      <= u_lo;
          integ[ch]       <= i_new_r;
          e_prev[ch]      <= e_r;
          if (!last_ch) ch <= ch + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // PWM: free-running counter, duty transferred from shadow only at wrap
  logic [WIDTH-1:0] cnt;
  logic [N_CH-1:0]  pwm_q;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      pwm_q <= '0;
      for (int k = 0; k < N_CH; k++) duty_active[k] <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
      for (int k = 0; k < N_CH; k++) begin
        pwm_q[k] <= (cnt < duty_active[k]);
        if (!enable_i)            duty_active[k] <= '0;
        else if (cnt == DUTY_MAX) duty_active[k] <= duty_shadow[k];
      end
    end
  end

  assign pwm_o = pwm_q & {N_CH{enable_i}};

endmodule

// File: doc/servo_pid_multi.md
Name: servo_pid_multi

Overview:
- Parametrised N-channel servo loop: one time-multiplexed PID datapath (single multiplier) plus N PWM generators.
- Each frame strobe snapshots N ADC samples and N references, computes N saturated PID outputs sequentially, then loads each result into its channel's glitch-free PWM.
- Replaces the fixed single-channel, fixed-coefficient controller/PWM pairing. Adds:
  - runtime coefficients
  - fixed-point scaling
  - anti-windup
  - saturation flags
  - overrun detection
  - enable control

Parameters:
- WIDTH, 12, sample/reference/coefficient/duty width; PWM period = 2^WIDTH clocks
- N_CH, 2, number of channels (1..8)
- FRAC, 8, fractional bits of coefficients (Q(WIDTH-FRAC).FRAC unsigned)
- ACCW, 16, signed integral accumulator width (ACCW > WIDTH+1)

Ports:
- clk_i  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable_i  in  1  loop enable
- dataf_i  in  1  frame strobe; 1-cycle pulse marks new samples valid
- adc_i  in  N_CH*WIDTH  unsigned feedback samples; channel k at [k*WIDTH +: WIDTH]
- ref_i  in  N_CH*WIDTH  unsigned setpoints, same packing
- kp_i, ki_i, kd_i  in  WIDTH each  unsigned gains, shared by all channels, sampled at frame start
- pwm_o  out  N_CH  PWM outputs
- sat_o  out  N_CH  per-channel flag: last result was clamped
- busy_o  out  1  frame computation in progress
- done_o  out  1  1-cycle pulse at frame completion
- overrun_o  out  1  1-cycle pulse when dataf_i arrives while busy

Behaviour:
- Reset (async) clears all state:
  - outputs: pwm_o, sat_o, busy_o, done_o, overrun_o = 0
  - integrators, e_prev, duty shadow/active, PWM counter, FSM = 0 / IDLE
- Frame start: dataf_i=1 with FSM IDLE and enable_i=1.
  - Latch adc_i, ref_i, kp_i, ki_i, kd_i into snapshot registers.
  - busy_o=1 from the next cycle.
- Per channel k, one state per cycle:
  - S_ERR: e = ref − adc, signed WIDTH+1; d = e − e_prev[k]; I_new = I[k] + e, saturated to ±(2^(ACCW−1)−1).
  - Anti-windup in S_ERR: if sat_hi[k] and e>0, or sat_lo[k] and e<0, then I_new = I[k] (hold). sat_hi/sat_lo come from the channel's previous frame.
  - S_P: acc = kp·e.
  - S_I: acc += ki·I_new.
  - S_D: acc += kd·d.
    - acc is signed, width WIDTH+ACCW+3; no overflow possible.
  - S_WR: u = acc >>> FRAC (arithmetic shift), clamped to [0, 2^WIDTH−1].
    - Write u to duty_shadow[k]; sat_o[k] = clamp occurred; record sat_hi/sat_lo.
    - Commit I[k]=I_new and e_prev[k]=e.
    - k++; after the last channel, go to S_DONE.
  - S_DONE: done_o=1, busy_o=0, return to IDLE.
- Latency: dataf_i edge to done_o = 5·N_CH+1 cycles (11 for N_CH=2).
- dataf_i while busy: ignored; overrun_o pulses 1 cycle; the running frame is unaffected.
- PWM:
  - Free-running WIDTH-bit counter cnt wraps 2^WIDTH−1 → 0.
  - pwm_o[k] = (cnt < duty_active[k]), registered.
  - When cnt = 2^WIDTH−1, duty_active ← duty_shadow. A shadow write on that same edge takes effect at the following wrap.
  - duty 0 → constant low; duty 2^WIDTH−1 → high 4095 of 4096 cycles (WIDTH=12).
- enable_i=0, effective next cycle:
  - FSM aborts to IDLE; busy_o=0; no done_o.
  - All I, e_prev, sat flags, duty_shadow and duty_active cleared.
  - pwm_o forced 0 immediately (combinational gate on the registered output).
  - The counter keeps running.
- enable_i rising: the next dataf_i starts a fresh frame.
- Reset mid-frame: everything clears; no done_o emitted.

Test Plan:
- N_CH=2, FRAC=8, kp=256, ki=kd=0. ch0 ref=1000, adc=400; ch1 ref=500, adc=500. Pulse dataf_i.
  - Required: done_o exactly 11 cycles later; duty0=600, duty1=0.
  - After the next wrap: pwm_o[0] high 600 of every 4096 cycles; pwm_o[1] stays low.
- kp=256, ref=100, adc=900 → u=−800 clamped to 0, sat_o[0]=1. Then ref=4095, adc=0 → duty 4095, sat_o[0]=0.
- Integral and anti-windup, kp=kd=0, ki=256:
  - e=10 over 3 frames → duty 10, 20, 30.
  - Then e=4000 repeatedly → I=4030 (duty 4030); next frame I=8030 → duty 4095 with sat_o=1; next frame I holds at 8030.
  - Then e=−100 → I=7930, duty still 4095.
- Derivative, kd=256: e sequence 0, 50, 50 → duty 0, 50, 0.
- Pulse dataf_i again 3 cycles into a frame → overrun_o 1-cycle pulse; original done_o timing and results unchanged.
- Mid-frame behaviour:
  - Drop enable_i mid-frame → busy_o=0 next cycle, no done_o, pwm_o=0; re-enable with kp=256, e=20 → duty 20, integrators restart from 0.
  - Assert reset mid-PWM-period → all outputs 0 asynchronously.
